// File: rtl/alu_exec_stage.sv
// ALU execute stage: single-cycle ops, iterative signed div/mod,
// registered E/GT flags and an upstream stall while a divide runs.
module alu_exec_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_ALU,
  input  logic              flush,
  input  logic [DATA_W-1:0] op1_ALU,
  input  logic [DATA_W-1:0] op2_ALU,
  input  logic [12:0]       aluSignals_ALU,
  output logic [DATA_W-1:0] aluResult,
  output logic              result_valid,
  output logic              stall_ALU,
  output logic              flag_E,
  output logic              flag_GT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [4:0]        count;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dvs;
  logic              neg_q;
  logic              neg_r;
  logic              is_mod;

  logic              one_hot;
  logic              is_dm;
  logic              is_cmp;
  logic              start;
  logic [DATA_W-1:0] comb_res;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W:0]   r_sh;
  logic [DATA_W:0]   r_diff;
  logic              r_ge;
  logic [DATA_W-1:0] div_out;

  assign one_hot = $onehot(aluSignals_ALU);
  assign is_dm   = one_hot
                 & (aluSignals_ALU[4] | aluSignals_ALU[5]);
  assign is_cmp  = one_hot & aluSignals_ALU[2];

  // A divide starts only from IDLE with a real, non-zero divisor
  assign start = (state == S_IDLE) & valid_ALU & ~flush
               & is_dm & (op2_ALU != '0);

  // Magnitudes; INT_MIN maps onto unsigned 0x80000000
  assign abs1 = op1_ALU[DATA_W-1] ? -op1_ALU : op1_ALU;
  assign abs2 = op2_ALU[DATA_W-1] ? -op2_ALU : op2_ALU;

  // One restoring step: shift in next dividend bit, try subtract
  assign r_sh   = {rem, quo[DATA_W-1]};
  assign r_diff = r_sh - {1'b0, dvs};
  assign r_ge   = ~r_diff[DATA_W];

  // Sign-corrected divider output
  assign div_out = is_mod ? (neg_r ? -rem : rem)
                          : (neg_q ? -quo : quo);

  // Single-cycle datapath for every op that needs no iteration
  always_comb begin
    comb_res = '0;
    if (one_hot) begin
      unique case (1'b1)
        aluSignals_ALU[0]:  comb_res = op1_ALU + op2_ALU;
        aluSignals_ALU[1]:  comb_res = op1_ALU - op2_ALU;
        aluSignals_ALU[2]:  comb_res = '0;
        aluSignals_ALU[3]:  comb_res = op1_ALU * op2_ALU;
        aluSignals_ALU[4]:  comb_res = '1;
        aluSignals_ALU[5]:  comb_res = op1_ALU;
        aluSignals_ALU[6]:  comb_res = op1_ALU << op2_ALU[4:0];
        aluSignals_ALU[7]:  comb_res = op1_ALU >> op2_ALU[4:0];
        aluSignals_ALU[8]:
          comb_res = $signed(op1_ALU) >>> op2_ALU[4:0];
        aluSignals_ALU[9]:  comb_res = op1_ALU | op2_ALU;
        aluSignals_ALU[10]: comb_res = op1_ALU & op2_ALU;
        aluSignals_ALU[11]: comb_res = ~op2_ALU;
        aluSignals_ALU[12]: comb_res = op2_ALU;
        default:            comb_res = '0;
      endcase
    end
  end

  // Output select; reset and flush silence the stage
  always_comb begin
    aluResult    = '0;
    result_valid = 1'b0;
    stall_ALU    = 1'b0;
    if (!reset && !flush) begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            stall_ALU = 1'b1;
          end else if (valid_ALU) begin
            result_valid = 1'b1;
            aluResult    = comb_res;
          end
        end
        S_CALC: stall_ALU = 1'b1;
        S_DONE: begin
          result_valid = 1'b1;
          aluResult    = div_out;
        end
        default: ;
      endcase
    end
  end

  // Divider FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      count  <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_mod <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            quo    <= abs1;
            rem    <= '0;
            dvs    <= abs2;
            neg_q  <= op1_ALU[DATA_W-1] ^ op2_ALU[DATA_W-1];
            neg_r  <= op1_ALU[DATA_W-1];
            is_mod <= aluSignals_ALU[5];
            count  <= '0;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          quo   <= {quo[DATA_W-2:0], r_ge};
          rem   <= r_ge ? r_diff[DATA_W-1:0]
                        : r_sh[DATA_W-1:0];
          count <= count + 5'd1;
          if (count == 5'd31) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Flags follow a committed compare only
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_E  <= 1'b0;
      flag_GT <= 1'b0;
    end else if ((state == S_IDLE) && valid_ALU
                 && !flush && is_cmp) begin
      flag_E  <= (op1_ALU == op2_ALU);
      flag_GT <= ($signed(op1_ALU) > $signed(op2_ALU));
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with an expected-result
// queue popped whenever the stage reports a valid result.
module tb_alu_exec_stage;

  logic        clk;
  logic        reset;
  logic        valid_ALU;
  logic        flush;
  logic [31:0] op1_ALU;
  logic [31:0] op2_ALU;
  logic [12:0] aluSignals_ALU;
  logic [31:0] aluResult;
  logic        result_valid;
  logic        stall_ALU;
  logic        flag_E;
  logic        flag_GT;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  localparam logic [12:0] ADD = 13'h0001;
  localparam logic [12:0] SUB = 13'h0002;
  localparam logic [12:0] CMP = 13'h0004;
  localparam logic [12:0] MUL = 13'h0008;
  localparam logic [12:0] DIV = 13'h0010;
  localparam logic [12:0] MOD = 13'h0020;
  localparam logic [12:0] LSL = 13'h0040;
  localparam logic [12:0] LSR = 13'h0080;
  localparam logic [12:0] ASR = 13'h0100;
  localparam logic [12:0] OR_ = 13'h0200;
  localparam logic [12:0] AND = 13'h0400;
  localparam logic [12:0] NOT = 13'h0800;
  localparam logic [12:0] MOV = 13'h1000;

  alu_exec_stage #(.DATA_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_ALU     (valid_ALU),
    .flush         (flush),
    .op1_ALU       (op1_ALU),
    .op2_ALU       (op2_ALU),
    .aluSignals_ALU(aluSignals_ALU),
    .aluResult     (aluResult),
    .result_valid  (result_valid),
    .stall_ALU     (stall_ALU),
    .flag_E        (flag_E),
    .flag_GT       (flag_GT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step to the middle of the next cycle after new inputs settle
  task automatic step();
    @(posedge clk);
    #4;
  endtask

  task automatic run_op(input string tag,
                        input logic [12:0] sig,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int exp_stall);
    int stalls;
    bit done;
    logic [31:0] want;
    @(posedge clk);
    #1;
    valid_ALU      = 1'b1;
    aluSignals_ALU = sig;
    op1_ALU        = a;
    op2_ALU        = b;
    exp_q.push_back(exp);
    stalls = 0;
    done   = 1'b0;
    #3;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) step();
      if (result_valid) begin
        want = exp_q.pop_front();
        chk(tag, aluResult, want);
        chk({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
        done = 1'b1;
      end else if (stall_ALU) begin
        stalls++;
      end
    end
    if (!done) begin
      void'(exp_q.pop_front());
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end
  endtask

  task automatic bubble();
    @(posedge clk);
    #1;
    valid_ALU      = 1'b0;
    aluSignals_ALU = '0;
    #3;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    valid_ALU = 1'b0;
    flush     = 1'b0;
    op1_ALU   = '0;
    op2_ALU   = '0;
    aluSignals_ALU = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #3;
    chk("rst_res", aluResult, 32'h0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_stall", 32'(stall_ALU), 32'd0);
    chk("rst_flags", {30'd0, flag_E, flag_GT}, 32'd0);

    run_op("add", ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0);
    run_op("sub", SUB, 32'd5, 32'd7, 32'hFFFFFFFE, 0);
    run_op("cmp_gt", CMP, 32'd5, 32'hFFFFFFFD, 32'h0, 0);
    bubble();
    chk("cmp_gt_flags", {30'd0, flag_E, flag_GT}, 32'd1);
    run_op("cmp_eq", CMP, 32'd9, 32'd9, 32'h0, 0);
    bubble();
    chk("cmp_eq_flags", {30'd0, flag_E, flag_GT}, 32'd2);
    chk("idle_rv", 32'(result_valid), 32'd0);

    run_op("mul", MUL, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 0);
    run_op("or", OR_, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F00F0F, 0);
    run_op("and", AND, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 0);
    run_op("not", NOT, 32'h1234, 32'h0000FFFF, 32'hFFFF0000, 0);
    run_op("mov", MOV, 32'h1, 32'hCAFEBABE, 32'hCAFEBABE, 0);
    run_op("asr", ASR, 32'h80000000, 32'h21, 32'hC0000000, 0);
    run_op("lsr", LSR, 32'h80000000, 32'h21, 32'h40000000, 0);
    run_op("lsl", LSL, 32'h1, 32'd31, 32'h80000000, 0);
    run_op("multi", ADD | SUB, 32'd3, 32'd4, 32'h0, 0);

    run_op("div", DIV, 32'd100, 32'd7, 32'd14, 33);
    run_op("mod", MOD, 32'd100, 32'd7, 32'd2, 33);
    run_op("ndiv", DIV, -32'sd7, 32'd2, 32'hFFFFFFFD, 33);
    run_op("nmod", MOD, -32'sd7, 32'd2, 32'hFFFFFFFF, 33);
    run_op("divn", DIV, 32'd7, -32'sd2, 32'hFFFFFFFD, 33);
    run_op("minov", DIV, 32'h80000000, 32'hFFFFFFFF,
           32'h80000000, 33);
    run_op("minmod", MOD, 32'h80000000, 32'hFFFFFFFF, 32'h0, 33);
    run_op("div0", DIV, 32'd42, 32'd0, 32'hFFFFFFFF, 0);
    run_op("mod0", MOD, 32'd42, 32'd0, 32'd42, 0);
    run_op("b2b_a", DIV, 32'd20, 32'd3, 32'd6, 33);
    run_op("b2b_b", DIV, 32'd20, 32'd3, 32'd6, 33);
    bubble();
    chk("flags_kept", {30'd0, flag_E, flag_GT}, 32'd2);

    // Flushed compare must not touch the flags
    @(posedge clk);
    #1;
    valid_ALU      = 1'b1;
    aluSignals_ALU = CMP;
    op1_ALU        = 32'd1;
    op2_ALU        = 32'd0;
    flush          = 1'b1;
    #3;
    chk("fcmp_rv", 32'(result_valid), 32'd0);
    bubble();
    flush = 1'b0;
    chk("fcmp_flags", {30'd0, flag_E, flag_GT}, 32'd2);

    // Flush a divide at CALC count 10
    @(posedge clk);
    #1;
    valid_ALU      = 1'b1;
    aluSignals_ALU = DIV;
    op1_ALU        = 32'd100;
    op2_ALU        = 32'd7;
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    #3;
    chk("fl_stall", 32'(stall_ALU), 32'd0);
    chk("fl_rv", 32'(result_valid), 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    valid_ALU = 1'b0;
    #3;
    chk("fl_next_stall", 32'(stall_ALU), 32'd0);
    chk("fl_next_rv", 32'(result_valid), 32'd0);
    chk("fl_flags", {30'd0, flag_E, flag_GT}, 32'd2);

    // Same abort through reset
    @(posedge clk);
    #1;
    valid_ALU = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    #3;
    chk("rs_stall", 32'(stall_ALU), 32'd0);
    chk("rs_rv", 32'(result_valid), 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    valid_ALU = 1'b0;
    #3;
    chk("rs_next_stall", 32'(stall_ALU), 32'd0);
    chk("rs_next_rv", 32'(result_valid), 32'd0);
    chk("rs_next_res", aluResult, 32'h0);
    chk("rs_flags", {30'd0, flag_E, flag_GT}, 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
